// File: rtl/ls_pkg.sv
// Shared types and float constants for the Armijo line-search sequencer.
package ls_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    CMP,
    SHRINK,
    DONE
  } state_t;

  localparam logic [31:0] FP_ONE  = 32'h3F800000;
  localparam logic [31:0] FP_HALF = 32'h3F000000;

endpackage

// File: rtl/float_mul.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even.
// Subnormal inputs and results are flushed to signed zero.
module float_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic        sign;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [23:0] ma;
  logic [23:0] mb;
  logic [47:0] prod;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [22:0] frac;
  logic        guard;
  logic        sticky;
  logic [23:0] frac_r;
  logic [9:0]  exp_s;
  logic [9:0]  exp_r;

  always_comb begin
    sign   = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    ma     = {1'b1, a[22:0]};
    mb     = {1'b1, b[22:0]};
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
    prod   = ma * mb;
    // exp_s is a biased exponent held as 10-bit two's complement so underflow stays visible
    exp_s  = {2'b00, ea} + {2'b00, eb} - 10'd127 + {9'd0, prod[47]};
    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    frac_r = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
    exp_r  = exp_s + {9'd0, frac_r[23]};
    y      = {sign, exp_r[7:0], frac_r[22:0]};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      y = 32'h7FC00000;
    end else if (a_inf || b_inf) begin
      y = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      y = {sign, 31'd0};
    end else if ($signed(exp_r) >= 10'sd255) begin
      y = {sign, 8'hFF, 23'd0};
    end else if ($signed(exp_r) <= 10'sd0) begin
      y = {sign, 31'd0};
    end
  end

endmodule

// File: rtl/ls_backtrack_ctrl.sv
// Backtracking (Armijo) line-search sequencer: issues trial alphas, collects phi,
// drives the sufficient-decrease comparator and shrinks alpha by tau on failure.
module ls_backtrack_ctrl
  import ls_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_ITER   = 16,
  parameter int CMP_WAIT   = 2,
  parameter int ITER_W     = $clog2(MAX_ITER + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] alpha_init,
  input  logic [DATA_WIDTH-1:0] tau,
  input  logic [DATA_WIDTH-1:0] phi0,
  input  logic [DATA_WIDTH-1:0] rho_phidif0,
  output logic                  eval_req,
  output logic [DATA_WIDTH-1:0] eval_alpha,
  input  logic                  eval_ack,
  input  logic [DATA_WIDTH-1:0] eval_phi,
  output logic [DATA_WIDTH-1:0] cmp_alphai,
  output logic [DATA_WIDTH-1:0] cmp_phi_alphai,
  output logic [DATA_WIDTH-1:0] cmp_phi0,
  output logic [DATA_WIDTH-1:0] cmp_rho_phidif0,
  input  logic                  result_compare,
  output logic                  busy,
  output logic                  done,
  output logic                  success,
  output logic [DATA_WIDTH-1:0] alpha_out,
  output logic [DATA_WIDTH-1:0] phi_out,
  output logic [ITER_W-1:0]     iter_out
);

  localparam int                WAIT_W    = (CMP_WAIT > 1) ? $clog2(CMP_WAIT) : 1;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(CMP_WAIT - 1);

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] alpha_reg, tau_reg, phi0_reg, rho_reg, phi_reg;
  logic [DATA_WIDTH-1:0] alpha_shrunk;
  logic [ITER_W-1:0]     iter;
  logic [ITER_W-1:0]     iter_inc;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  accept, eval_done, cmp_sample, finish;

  float_mul u_shrink (
    .a (alpha_reg),
    .b (tau_reg),
    .y (alpha_shrunk)
  );

  assign iter_inc        = iter + ITER_W'(1);
  assign eval_alpha      = alpha_reg;
  assign cmp_alphai      = alpha_reg;
  assign cmp_phi_alphai  = phi_reg;
  assign cmp_phi0        = phi0_reg;
  assign cmp_rho_phidif0 = rho_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    eval_done  = 1'b0;
    cmp_sample = 1'b0;
    finish     = 1'b0;
    eval_req   = (state == EVAL);
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        next_state = EVAL;
      end
      EVAL: if (eval_ack) begin
        eval_done  = 1'b1;
        next_state = CMP;
      end
      CMP: if (wait_cnt == LAST_WAIT) begin
        // Verdict is taken only once the comparator's register stage has settled
        cmp_sample = 1'b1;
        finish     = result_compare || (iter_inc == LAST_ITER);
        next_state = finish ? DONE : SHRINK;
      end
      SHRINK:  next_state = EVAL;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      alpha_reg <= '0;
      tau_reg   <= '0;
      phi0_reg  <= '0;
      rho_reg   <= '0;
      phi_reg   <= '0;
      iter      <= '0;
      wait_cnt  <= '0;
      success   <= 1'b0;
      alpha_out <= '0;
      phi_out   <= '0;
      iter_out  <= '0;
    end else begin
      if (accept) begin
        alpha_reg <= alpha_init;
        tau_reg   <= tau;
        phi0_reg  <= phi0;
        rho_reg   <= rho_phidif0;
        iter      <= '0;
        success   <= 1'b0;
      end
      if (eval_done) phi_reg <= eval_phi;
      if (state == CMP && !cmp_sample) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                             wait_cnt <= '0;
      if (cmp_sample && !result_compare) iter <= iter_inc;
      if (finish) begin
        success   <= result_compare;
        alpha_out <= alpha_reg;
        phi_out   <= phi_reg;
        iter_out  <= result_compare ? iter : iter_inc;
      end
      if (state == SHRINK) alpha_reg <= alpha_shrunk;
    end
  end

endmodule

// File: tb/tb_ls_backtrack_ctrl.sv
// Self-checking bench for ls_backtrack_ctrl: the bench plays evaluator and comparator,
// and predicts trial alphas, timing and results from real-valued arithmetic.
module tb_ls_backtrack_ctrl;
  import ls_pkg::*;

  localparam int DATA_WIDTH = 32;
  localparam int MAX_ITER   = 4;
  localparam int CMP_WAIT   = 2;
  localparam int ITER_W     = $clog2(MAX_ITER + 1);

  logic                  aclk;
  logic                  aresetn;
  logic                  start;
  logic [DATA_WIDTH-1:0] alpha_init, tau, phi0, rho_phidif0;
  logic                  eval_req;
  logic [DATA_WIDTH-1:0] eval_alpha;
  logic                  eval_ack;
  logic [DATA_WIDTH-1:0] eval_phi;
  logic [DATA_WIDTH-1:0] cmp_alphai, cmp_phi_alphai, cmp_phi0, cmp_rho_phidif0;
  logic                  result_compare;
  logic                  busy, done, success;
  logic [DATA_WIDTH-1:0] alpha_out, phi_out;
  logic [ITER_W-1:0]     iter_out;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] hold_alpha_out = '0;
  logic [31:0] hold_phi_out   = '0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  ls_backtrack_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_ITER   (MAX_ITER),
    .CMP_WAIT   (CMP_WAIT),
    .ITER_W     (ITER_W)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .start           (start),
    .alpha_init      (alpha_init),
    .tau             (tau),
    .phi0            (phi0),
    .rho_phidif0     (rho_phidif0),
    .eval_req        (eval_req),
    .eval_alpha      (eval_alpha),
    .eval_ack        (eval_ack),
    .eval_phi        (eval_phi),
    .cmp_alphai      (cmp_alphai),
    .cmp_phi_alphai  (cmp_phi_alphai),
    .cmp_phi0        (cmp_phi0),
    .cmp_rho_phidif0 (cmp_rho_phidif0),
    .result_compare  (result_compare),
    .busy            (busy),
    .done            (done),
    .success         (success),
    .alpha_out       (alpha_out),
    .phi_out         (phi_out),
    .iter_out        (iter_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic real f32ToReal(input logic [31:0] f);
    real r;
    int  e;
    r = 1.0 + $itor(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return r;
  endfunction

  // Only used on positive, exactly representable products
  function automatic logic [31:0] realToF32(input real x);
    real m;
    int  e;
    m = x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {1'b0, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  task automatic applyStimulus(input logic [31:0] a0, input logic [31:0] t,
                               input logic [31:0] p0, input logic [31:0] r0,
                               input int pass_idx, input int min_dly, input int max_dly,
                               input bit noise);
    logic [31:0] exp_alpha;
    logic [31:0] phi_val;
    int          n_trials, start_cyc, exp_lat, waited, dly;
    bit          exp_success;
    n_trials    = (pass_idx < MAX_ITER) ? pass_idx + 1 : MAX_ITER;
    exp_success = (pass_idx < MAX_ITER);
    exp_alpha   = a0;
    exp_lat     = 1;
    phi_val     = '0;
    @(negedge aclk);
    start       = 1'b1;
    alpha_init  = a0;
    tau         = t;
    phi0        = p0;
    rho_phidif0 = r0;
    start_cyc   = cyc;
    for (int i = 0; i < n_trials; i++) begin
      if (i > 0) begin
        exp_alpha = realToF32(f32ToReal(exp_alpha) * f32ToReal(t));
        exp_lat   = exp_lat + 1;
      end
      waited = 0;
      do begin
        @(negedge aclk);
        start          = 1'b0;
        result_compare = 1'b0;
        waited++;
      end while (!eval_req && waited < 8);
      if (!eval_req) begin
        checkOutput("eval_req_timeout", {31'd0, eval_req}, 32'd1);
        return;
      end
      checkOutput("eval_alpha", eval_alpha, exp_alpha);
      checkOutput("busy_eval", {31'd0, busy}, 32'd1);
      dly     = $urandom_range(max_dly, min_dly);
      exp_lat = exp_lat + 1 + dly + CMP_WAIT;
      for (int k = 0; k < dly; k++) begin
        if (noise && $urandom_range(2, 0) == 0) begin
          start      = 1'b1;
          alpha_init = $urandom;
        end
        @(negedge aclk);
        start = 1'b0;
        checkOutput("eval_req_held", {31'd0, eval_req}, 32'd1);
        checkOutput("eval_alpha_held", eval_alpha, exp_alpha);
      end
      phi_val  = $urandom;
      eval_ack = 1'b1;
      eval_phi = phi_val;
      for (int j = 0; j < CMP_WAIT; j++) begin
        @(negedge aclk);
        eval_ack       = 1'b0;
        eval_phi       = $urandom;
        result_compare = (i == pass_idx);
        checkOutput("eval_req_cmp", {31'd0, eval_req}, 32'd0);
        checkOutput("cmp_alphai", cmp_alphai, exp_alpha);
        checkOutput("cmp_phi_alphai", cmp_phi_alphai, phi_val);
        checkOutput("cmp_phi0", cmp_phi0, p0);
        checkOutput("cmp_rho_phidif0", cmp_rho_phidif0, r0);
      end
    end
    @(negedge aclk);
    result_compare = 1'b0;
    checkOutput("done", {31'd0, done}, 32'd1);
    checkOutput("done_latency", 32'(cyc - start_cyc), 32'(exp_lat));
    checkOutput("success", {31'd0, success}, {31'd0, exp_success});
    checkOutput("alpha_out", alpha_out, exp_alpha);
    checkOutput("phi_out", phi_out, phi_val);
    checkOutput("iter_out", 32'(iter_out), exp_success ? 32'(pass_idx) : 32'(MAX_ITER));
    hold_alpha_out = exp_alpha;
    hold_phi_out   = phi_val;
    @(negedge aclk);
    checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
    checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
    checkOutput("success_hold", {31'd0, success}, {31'd0, exp_success});
    checkOutput("alpha_out_hold", alpha_out, hold_alpha_out);
  endtask

  logic [31:0] tau_set [4] = '{32'h3F000000, 32'h3E800000, 32'h3F400000, 32'h3F200000};

  initial begin
    aresetn        = 1'b0;
    start          = 1'b0;
    alpha_init     = '0;
    tau            = '0;
    phi0           = '0;
    rho_phidif0    = '0;
    eval_ack       = 1'b0;
    eval_phi       = '0;
    result_compare = 1'b0;
    #3;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_eval_req", {31'd0, eval_req}, 32'd0);
    checkOutput("rst_eval_alpha", eval_alpha, 32'd0);
    checkOutput("rst_alpha_out", alpha_out, 32'd0);
    checkOutput("rst_iter_out", 32'(iter_out), 32'd0);
    checkOutput("rst_success", {31'd0, success}, 32'd0);
    checkOutput("rst_cmp_phi0", cmp_phi0, 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    applyStimulus(FP_ONE, FP_HALF, 32'h40000000, 32'hBF800000, 0, 0, 0, 1'b0);
    applyStimulus(FP_ONE, FP_HALF, 32'h40000000, 32'hBF800000, 2, 0, 0, 1'b0);
    applyStimulus(FP_ONE, FP_HALF, 32'h40000000, 32'hBF800000, MAX_ITER, 0, 0, 1'b0);
    applyStimulus(FP_ONE, FP_HALF, 32'h41200000, 32'hBE000000, 1, 5, 5, 1'b1);

    // Stray ack in IDLE must not start anything or disturb held results
    @(negedge aclk);
    eval_ack = 1'b1;
    eval_phi = 32'hDEADBEEF;
    @(negedge aclk);
    eval_ack = 1'b0;
    checkOutput("idle_ack_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_ack_done", {31'd0, done}, 32'd0);
    checkOutput("idle_ack_phi_out", phi_out, hold_phi_out);
    @(negedge aclk);
    checkOutput("idle_ack_busy2", {31'd0, busy}, 32'd0);

    // Abort mid-EVAL with an asynchronous reset
    start      = 1'b1;
    alpha_init = FP_ONE;
    tau        = FP_HALF;
    @(negedge aclk);
    start = 1'b0;
    checkOutput("abort_eval_req", {31'd0, eval_req}, 32'd1);
    #2 aresetn = 1'b0;
    #1;
    checkOutput("abort_eval_req_low", {31'd0, eval_req}, 32'd0);
    checkOutput("abort_busy_low", {31'd0, busy}, 32'd0);
    checkOutput("abort_done_low", {31'd0, done}, 32'd0);
    checkOutput("abort_alpha_out", alpha_out, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    applyStimulus(32'h40400000, FP_HALF, 32'h3F800000, 32'hBF000000, 0, 0, 2, 1'b0);

    for (int n = 0; n < 25; n++) begin
      logic [31:0] a0;
      a0 = {1'b0, 8'($urandom_range(134, 120)), 8'($urandom), 15'd0};
      applyStimulus(a0, tau_set[$urandom_range(3, 0)], $urandom, $urandom,
                    $urandom_range(MAX_ITER, 0), 0, 3, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
